meter_ctrl: RTL and testbench



---
 rtl/meter_pkg.sv | 17 +
 rtl/edge_rise.sv | 19 +
 rtl/meter_ctrl.sv | 117 +++++++++++
 tb/tb_meter_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/meter_pkg.sv
// meter_pkg: shared encodings and defaults for the parking meter front end.
// Imported by meter_ctrl; the scanner sees only VAL_W-wide values.
package meter_pkg;

  localparam int VAL_W = 20;
  localparam int MAX_VAL = 99;
  localparam int COIN1_VAL = 1;
  localparam int COIN5_VAL = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/edge_rise.sv
// edge_rise: registered rising-edge detector; prev resets high so a
// level held through reset is not seen as an edge.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= d;
  end

  assign pulse = d & ~prev;

endmodule

// File: rtl/meter_ctrl.sv
// meter_ctrl: coin accumulation, money-to-time conversion and 1 Hz
// countdown feeding the 4-digit display scanner.
module meter_ctrl #(
  parameter int TICK_DIV      = 1000,
  parameter int TIME_PER_YUAN = 2,
  parameter int MAX_VAL       = meter_pkg::MAX_VAL
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        coin1,
  input  logic                        coin5,
  input  logic                        start,
  input  logic                        clear,
  output logic [meter_pkg::VAL_W-1:0] time_left,
  output logic [meter_pkg::VAL_W-1:0] money,
  output logic                        running,
  output logic                        expired
);

  import meter_pkg::*;

  localparam int W1 = VAL_W + 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [W1-1:0] MAXW = W1'(MAX_VAL);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic c1_p;
  logic c5_p;
  logic st_p;
  logic cl_p;

  edge_rise u_c1 (.clk(clk), .rst_n(rst_n), .d(coin1), .pulse(c1_p));
  edge_rise u_c5 (.clk(clk), .rst_n(rst_n), .d(coin5), .pulse(c5_p));
  edge_rise u_st (.clk(clk), .rst_n(rst_n), .d(start), .pulse(st_p));
  edge_rise u_cl (.clk(clk), .rst_n(rst_n), .d(clear), .pulse(cl_p));

  state_t            state;
  logic [PW-1:0]     presc;
  logic              tick;
  logic              in_sess;
  logic [W1-1:0]     add;
  logic [W1-1:0]     credit;
  logic [W1-1:0]     m_sum;
  logic [W1-1:0]     t_sum;
  logic [VAL_W-1:0]  m_sat;
  logic [VAL_W-1:0]  t_sat;

  // IDLE and DONE start a fresh session, so they credit from zero
  always_comb begin
    in_sess = (state == ACCUM) || (state == RUN);
    tick    = (state == RUN) && (presc == LAST);
    add     = '0;
    if (c1_p) add = add + W1'(COIN1_VAL);
    if (c5_p) add = add + W1'(COIN5_VAL);
    credit  = add * W1'(TIME_PER_YUAN);
    m_sum   = add + (in_sess ? {1'b0, money} : '0);
    t_sum   = credit + (in_sess ? {1'b0, time_left} : '0) - W1'(tick);
    m_sat   = (m_sum > MAXW) ? MAXW[VAL_W-1:0] : m_sum[VAL_W-1:0];
    t_sat   = (t_sum > MAXW) ? MAXW[VAL_W-1:0] : t_sum[VAL_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      money     <= '0;
      time_left <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
    end else if (cl_p) begin
      state     <= IDLE;
      presc     <= '0;
      money     <= '0;
      time_left <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (add != '0) begin
            state     <= ACCUM;
            money     <= m_sat;
            time_left <= t_sat;
          end
        end
        ACCUM: begin
          money     <= m_sat;
          time_left <= t_sat;
          if (st_p && (m_sat != '0)) begin
            state   <= RUN;
            presc   <= '0;
            running <= 1'b1;
          end
        end
        RUN: begin
          money     <= m_sat;
          time_left <= t_sat;
          presc     <= tick ? '0 : presc + 1'b1;
          if (tick && (t_sat == '0)) begin
            state   <= DONE;
            running <= 1'b0;
            expired <= 1'b1;
          end
        end
        DONE: begin
          if (add != '0) begin
            state     <= ACCUM;
            money     <= m_sat;
            time_left <= t_sat;
            expired   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meter_ctrl.sv
// tb_meter_ctrl: vector table, directed corner sequences and random
// stimulus against a behavioural meter model.
module tb_meter_ctrl;

  localparam int TD  = 4;
  localparam int TPY = 2;
  localparam int MX  = 99;

  localparam int M_IDLE = 0;
  localparam int M_ACC  = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        coin1 = 1'b0;
  logic        coin5 = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [19:0] time_left;
  logic [19:0] money;
  logic        running;
  logic        expired;

  meter_ctrl #(
    .TICK_DIV(TD),
    .TIME_PER_YUAN(TPY),
    .MAX_VAL(MX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .coin1(coin1),
    .coin5(coin5),
    .start(start),
    .clear(clear),
    .time_left(time_left),
    .money(money),
    .running(running),
    .expired(expired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int ms, mm, mt, rc;
  bit pv1, pv5, pvs, pvc;

  typedef struct {
    logic c1, c5, st, cl;
    int   money, tleft;
    logic run, exp;
  } vec_t;

  vec_t tbl[8];

  function automatic int min99(input int v);
    return (v > MX) ? MX : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = M_IDLE; mm = 0; mt = 0; rc = 0;
    pv1 = 1; pv5 = 1; pvs = 1; pvc = 1;
  endtask

  task automatic model_step(input logic c1, c5, st, cl);
    int p1, p5, ps, pc, add, cr, tk;
    p1 = (c1 && !pv1) ? 1 : 0;
    p5 = (c5 && !pv5) ? 1 : 0;
    ps = (st && !pvs) ? 1 : 0;
    pc = (cl && !pvc) ? 1 : 0;
    pv1 = c1; pv5 = c5; pvs = st; pvc = cl;
    add = p1 + 5 * p5;
    cr  = TPY * add;
    if (pc != 0) begin
      ms = M_IDLE; mm = 0; mt = 0; rc = 0;
    end else begin
      case (ms)
        M_IDLE, M_DONE: begin
          if (add > 0) begin
            ms = M_ACC; mm = add; mt = min99(cr);
          end
        end
        M_ACC: begin
          mm = min99(mm + add);
          mt = min99(mt + cr);
          if (ps != 0 && mm > 0) begin
            ms = M_RUN; rc = 0;
          end
        end
        default: begin
          rc++;
          tk = (rc % TD == 0) ? 1 : 0;
          mm = min99(mm + add);
          mt = min99(mt - tk + cr);
          if (tk != 0 && mt == 0) ms = M_DONE;
        end
      endcase
    end
  endtask

  task automatic step(input logic c1, c5, st, cl);
    coin1 = c1; coin5 = c5; start = st; clear = cl;
    @(posedge clk);
    model_step(c1, c5, st, cl);
    #1;
    chk("money", int'(money), mm);
    chk("time_left", int'(time_left), mt);
    chk("running", int'(running), (ms == M_RUN) ? 1 : 0);
    chk("expired", int'(expired), (ms == M_DONE) ? 1 : 0);
  endtask

  task automatic do_reset(input logic c1hold);
    rst_n = 1'b0;
    coin1 = c1hold; coin5 = 0; start = 0; clear = 0;
    model_reset();
    #1;
    chk("rst_money", int'(money), 0);
    chk("rst_time", int'(time_left), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_expired", int'(expired), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string nm, input int m, t, r, e);
    chk({nm, "_money"}, int'(money), m);
    chk({nm, "_time"}, int'(time_left), t);
    chk({nm, "_running"}, int'(running), r);
    chk({nm, "_expired"}, int'(expired), e);
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 0, 1, 2, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 1, 2, 0, 0};
    tbl[4] = '{0, 1, 0, 0, 6, 12, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 6, 12, 0, 0};
    tbl[6] = '{0, 0, 1, 0, 6, 12, 1, 0};
    tbl[7] = '{0, 0, 0, 0, 6, 12, 1, 0};

    // coin1 held high through reset release
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].c1, tbl[i].c5, tbl[i].st, tbl[i].cl);
      chk_out($sformatf("vec%0d", i), tbl[i].money, tbl[i].tleft,
              int'(tbl[i].run), int'(tbl[i].exp));
    end

    // countdown: one decrement every TD cycles, 48 RUN cycles total
    for (int k = 2; k <= 48; k++) begin
      step(0, 0, 0, 0);
      chk("cd_time", int'(time_left), 12 - k / TD);
    end
    chk_out("done", 6, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk_out("done_start", 6, 0, 0, 1);

    // simultaneous coins from IDLE
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk_out("clr", 0, 0, 0, 0);
    step(1, 1, 0, 0);
    chk_out("both", 6, 12, 0, 0);
    step(0, 0, 0, 0);

    // saturation
    for (int i = 0; i < 21; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end
    chk_out("sat", 99, 99, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk_out("sat_c1", 99, 99, 0, 0);

    // coin coincident with a tick at time_left=3
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk_out("pre_run", 2, 4, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk_out("t3", 2, 3, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk_out("tick_coin", 3, 4, 1, 0);

    // clear coincident with coin5 mid-RUN
    step(0, 1, 0, 1);
    chk_out("clr_run", 0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk_out("idle_start", 0, 0, 0, 0);

    // asynchronous reset mid-RUN
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk_out("pre_rst", 5, 10, 1, 0);
    #2;
    do_reset(1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit quiet;
      logic c1, c5, st, cl;
      quiet = (i % 300) >= 40;
      c1 = !quiet && ($urandom_range(0, 2) == 0);
      c5 = !quiet && ($urandom_range(0, 5) == 0);
      st = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 249) == 0);
      step(c1, c5, st, cl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
